// File: rtl/mfp_gpio_debounce_pkg.sv
// Parameter defaults for the GPIO debouncer, sourced from the shared MFP constants header.
package mfp_gpio_debounce_pkg;
`include "mfp_ahb_const.vh"

    localparam int unsigned MFP_N_SW_C      = `MFP_N_SW;
    localparam int unsigned MFP_DB_CYCLES_C = `MFP_DB_CYCLES;
    localparam int unsigned MFP_CNT_W_C     = 16;

endpackage

// File: rtl/mfp_ahb_const.vh
// Shared MFP constants: switch count and default debounce length.
`ifndef MFP_AHB_CONST_VH
`define MFP_AHB_CONST_VH
`define MFP_N_SW      16
`define MFP_DB_CYCLES 16
`endif

// File: rtl/mfp_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, debounced bit and
// single-cycle accept strobes for rising/falling transitions.
module mfp_debounce_ch #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic raw_i,
    output logic db_o,
    output logic rise_c,
    output logic fall_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit_c;

    // Any sample agreeing with db_q throws away the partial count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        hit_c = 1'b0;
        if (s2_q != db_q) begin
            if (cnt_q >= CNT_MAX) begin
                hit_c = 1'b1;
                db_d  = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_q  <= RESET_VAL;
            s2_q  <= RESET_VAL;
            db_q  <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o   = db_q;
    assign rise_c = hit_c & s2_q;
    assign fall_c = hit_c & ~s2_q;

endmodule

// File: rtl/mfp_gpio_debounce.sv
// Multi-channel GPIO debouncer with sticky W1C rise/fall flags and a masked interrupt.
module mfp_gpio_debounce
    import mfp_gpio_debounce_pkg::*;
#(
    parameter int unsigned     N_CH      = MFP_N_SW_C,
    parameter int unsigned     DB_CYCLES = MFP_DB_CYCLES_C,
    parameter int unsigned     CNT_W     = MFP_CNT_W_C,
    parameter logic [N_CH-1:0] RESET_VAL = '0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_flags,
    output logic [N_CH-1:0] fall_flags,
    input  logic            clr_valid,
    input  logic [N_CH-1:0] clr_rise,
    input  logic [N_CH-1:0] clr_fall,
    input  logic [N_CH-1:0] en_rise,
    input  logic [N_CH-1:0] en_fall,
    output logic            irq
);

    logic [N_CH-1:0] rise_set_c;
    logic [N_CH-1:0] fall_set_c;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_q;
    logic [N_CH-1:0] fall_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mfp_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .HCLK   (HCLK),
            .HRESET (HRESET),
            .raw_i  (in_raw[i]),
            .db_o   (db_out[i]),
            .rise_c (rise_set_c[i]),
            .fall_c (fall_set_c[i])
        );
    end

    // Clear applies first, then a same-edge set overrides it.
    always_comb begin
        rise_d = rise_q | rise_set_c;
        fall_d = fall_q | fall_set_c;
        if (clr_valid) begin
            rise_d = (rise_q & ~clr_rise) | rise_set_c;
            fall_d = (fall_q & ~clr_fall) | fall_set_c;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_flags = rise_q;
    assign fall_flags = fall_q;
    assign irq        = |((rise_q & en_rise) | (fall_q & en_fall));

endmodule

// File: tb/tb_mfp_gpio_debounce.sv
// Directed bench for mfp_gpio_debounce (16 channels, 4-cycle debounce, zero reset value).
module tb_mfp_gpio_debounce;

    localparam int unsigned N = 16;

    logic         HCLK;
    logic         HRESET;
    logic [N-1:0] in_raw;
    logic [N-1:0] db_out;
    logic [N-1:0] rise_flags;
    logic [N-1:0] fall_flags;
    logic         clr_valid;
    logic [N-1:0] clr_rise;
    logic [N-1:0] clr_fall;
    logic [N-1:0] en_rise;
    logic [N-1:0] en_fall;
    logic         irq;

    int n_chk  = 0;
    int n_pass = 0;

    mfp_gpio_debounce #(
        .N_CH      (N),
        .DB_CYCLES (4),
        .CNT_W     (16),
        .RESET_VAL (16'h0000)
    ) u_dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .in_raw     (in_raw),
        .db_out     (db_out),
        .rise_flags (rise_flags),
        .fall_flags (fall_flags),
        .clr_valid  (clr_valid),
        .clr_rise   (clr_rise),
        .clr_fall   (clr_fall),
        .en_rise    (en_rise),
        .en_fall    (en_fall),
        .irq        (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET    = 1'b1;
        in_raw    = 16'habcd;
        clr_valid = 1'b0;
        clr_rise  = '0;
        clr_fall  = '0;
        en_rise   = '0;
        en_fall   = '0;

        // Reset hold with a live input, then release and time acceptance.
        tick(10);
        chk("rst_db", 32'(db_out), 32'h0);
        chk("rst_rise", 32'(rise_flags), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        HRESET = 1'b0;
        tick(5);
        chk("rel_db_e5", 32'(db_out), 32'h0);
        tick(1);
        chk("rel_db_e6", 32'(db_out), 32'habcd);
        chk("rel_rise", 32'(rise_flags), 32'habcd);
        chk("rel_fall", 32'(fall_flags), 32'h0);

        // Two-cycle glitch low on bit 0 is rejected.
        in_raw[0] = 1'b0;
        tick(2);
        in_raw[0] = 1'b1;
        tick(10);
        chk("glitch_db", 32'(db_out), 32'habcd);
        chk("glitch_fall", 32'(fall_flags), 32'h0);

        // Settle on 1234, clear all flags, then step to 0011.
        in_raw = 16'h1234;
        tick(8);
        chk("to1234_db", 32'(db_out), 32'h1234);
        clr_valid = 1'b1; clr_rise = '1; clr_fall = '1;
        tick(1);
        clr_valid = 1'b0; clr_rise = '0; clr_fall = '0;
        chk("clrall_rise", 32'(rise_flags), 32'h0);
        chk("clrall_fall", 32'(fall_flags), 32'h0);
        in_raw = 16'h0011;
        tick(5);
        chk("step_db_e5", 32'(db_out), 32'h1234);
        tick(1);
        chk("step_db_e6", 32'(db_out), 32'h0011);
        chk("step_fall", 32'(fall_flags), 32'h1224);
        chk("step_rise", 32'(rise_flags), 32'h0001);

        // Enable masking, clear ignored without valid, W1C drop of irq.
        en_rise = 16'h0001;
        en_fall = 16'h0000;
        #1;
        chk("irq_en", 32'(irq), 32'h1);
        tick(1);
        chk("en_keeps_rise", 32'(rise_flags), 32'h0001);
        clr_fall = '1;
        tick(1);
        clr_fall = '0;
        chk("clr_novalid", 32'(fall_flags), 32'h1224);
        clr_valid = 1'b1; clr_rise = 16'h0001;
        #1;
        chk("irq_before_clr", 32'(irq), 32'h1);
        tick(1);
        clr_valid = 1'b0; clr_rise = '0;
        chk("irq_after_clr", 32'(irq), 32'h0);
        chk("rise_after_clr", 32'(rise_flags), 32'h0);
        en_fall = '1;
        #1;
        chk("irq_fall_en", 32'(irq), 32'h1);

        // Clear of everything on the edge where db_out[3] rises: set wins.
        in_raw = 16'h0019;
        tick(5);
        clr_valid = 1'b1; clr_rise = '1; clr_fall = '1;
        tick(1);
        clr_valid = 1'b0; clr_rise = '0; clr_fall = '0;
        chk("setwin_db", 32'(db_out), 32'h0019);
        chk("setwin_rise", 32'(rise_flags), 32'h0008);
        chk("setwin_fall", 32'(fall_flags), 32'h0);

        // Async reset mid-count (counter at 2) discards progress.
        in_raw = 16'hffff;
        tick(4);
        #3;
        HRESET = 1'b1;
        #1;
        chk("arst_db", 32'(db_out), 32'h0);
        chk("arst_rise", 32'(rise_flags), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        tick(2);
        HRESET = 1'b0;
        tick(5);
        chk("arst_db_e5", 32'(db_out), 32'h0);
        tick(1);
        chk("arst_db_e6", 32'(db_out), 32'hffff);
        chk("arst_rise_e6", 32'(rise_flags), 32'hffff);

        // Input equal to reset value after release raises nothing.
        in_raw = 16'h0000;
        HRESET = 1'b1;
        tick(2);
        HRESET = 1'b0;
        tick(10);
        chk("quiet_db", 32'(db_out), 32'h0);
        chk("quiet_rise", 32'(rise_flags), 32'h0);
        chk("quiet_fall", 32'(fall_flags), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
